// File: rtl/conv1_engine_if.sv
// Frame-level bus between the first conv stage and its neighbours: image/kernel
// inputs with a start request, status flags and the registered feature maps.
interface conv1_engine_if;
    logic                    start;
    logic [0:27][0:27]       img_in;
    logic [0:19][0:24]       weights;
    logic [0:19][4:0]        thresh;
    logic                    busy;
    logic                    done;
    logic                    fmaps_valid;
    logic [0:19][0:23][0:23] fmaps_out;

    modport master (
        output start, img_in, weights, thresh,
        input  busy, done, fmaps_valid, fmaps_out
    );

    modport slave (
        input  start, img_in, weights, thresh,
        output busy, done, fmaps_valid, fmaps_out
    );
endinterface

// File: rtl/conv1_engine.sv
// First binary-CNN convolution: 5x5 XNOR-popcount over a latched 28x28 image,
// one output position per cycle with all 20 channels evaluated in parallel.
module conv1_engine (
    input  logic           clk,
    input  logic           rst_n,
    conv1_engine_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  r_state;
    logic [0:27][0:27]       r_img_q;
    logic [4:0]              r_row;
    logic [4:0]              r_col;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_valid;
    logic [0:19][0:23][0:23] r_fmaps;

    logic [0:24]             w_win;
    logic [0:19]             w_pix;

    function automatic logic [4:0] popcnt25(input logic [0:24] m);
        logic [4:0] s;
        s = '0;
        for (int i = 0; i < 25; i++) s = s + 5'(m[i]);
        return s;
    endfunction

    // Unsigned compare; thresholds above 25 can never be reached.
    function automatic logic thresh_hit(input logic [4:0] pc, input logic [4:0] th);
        return (pc >= th);
    endfunction

    // Window ordering matches the kernel index i = 5*kr + kc.
    always_comb begin
        w_win = '0;
        for (int kr = 0; kr < 5; kr++) begin
            for (int kc = 0; kc < 5; kc++) begin
                w_win[5'(5 * kr + kc)] = r_img_q[r_row + 5'(kr)][r_col + 5'(kc)];
            end
        end
    end

    always_comb begin
        w_pix = '0;
        for (int ch = 0; ch < 20; ch++) begin
            w_pix[ch] = thresh_hit(popcnt25(~(w_win ^ bus.weights[ch])), bus.thresh[ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_img_q <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_fmaps <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_img_q <= bus.img_in;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    for (int ch = 0; ch < 20; ch++) begin
                        r_fmaps[ch][r_row][r_col] <= w_pix[ch];
                    end
                    if (r_col == 5'd23) begin
                        r_col <= '0;
                        if (r_row == 5'd23) begin
                            r_row   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_valid <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_row <= r_row + 5'd1;
                        end
                    end else begin
                        r_col <= r_col + 5'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.fmaps_valid = r_valid;
    assign bus.fmaps_out   = r_fmaps;
endmodule

// File: tb/tb_conv1_engine.sv
// Directed bench for conv1_engine: reset, all-ones, checkerboard, threshold
// extremes, ignored start/image during RUN, and reset in the middle of a frame.
module tb_conv1_engine;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  int   lat, nbusy, ndone;
  logic [0:19][0:23][0:23] exp_map;
  logic [0:19][0:23][0:23] cb_map;
  logic [0:19][0:23][0:23] snap;

  conv1_engine_if bus ();

  conv1_engine dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input bit ok);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic run_frame(input bit toggle, output int lat_o, output int nbusy_o, output int ndone_o);
    lat_o   = 0;
    nbusy_o = 0;
    ndone_o = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!toggle) bus.start = 1'b0;
    check("accept_busy", bus.busy === 1'b1);
    check("accept_valid", bus.fmaps_valid === 1'b0);
    if (bus.busy === 1'b1) nbusy_o++;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clk);
      if (toggle) begin
        if (bus.busy === 1'b1) begin
          bus.img_in = ~bus.img_in;
          bus.start  = ~bus.start;
        end else begin
          bus.start = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1) nbusy_o++;
      if (bus.done === 1'b1) begin
        ndone_o++;
        if (lat_o == 0) begin
          lat_o = i;
          check("done_valid", bus.fmaps_valid === 1'b1);
        end
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic set_checkerboard();
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        bus.img_in[r][c] = 1'((r + c) % 2);
    for (int ch = 0; ch < 20; ch++) begin
      bus.weights[ch] = 25'($urandom);
      bus.thresh[ch]  = (ch < 2) ? 5'd25 : 5'd0;
    end
    for (int i = 0; i < 25; i++) begin
      bus.weights[0][i] = 1'(((i / 5) + (i % 5)) % 2);
      bus.weights[1][i] = ~bus.weights[0][i];
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset with random inputs present
    rst_n       = 1'b1;
    bus.start   = 1'b0;
    bus.img_in  = {25{32'($urandom)}};
    bus.weights = {16{32'($urandom)}};
    bus.thresh  = 100'({4{32'($urandom)}});
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy === 1'b0);
    check("rst_done", bus.done === 1'b0);
    check("rst_valid", bus.fmaps_valid === 1'b0);
    check("rst_map", bus.fmaps_out === '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // All-ones frame
    bus.img_in  = '1;
    bus.weights = '1;
    for (int ch = 0; ch < 20; ch++) bus.thresh[ch] = 5'd25;
    run_frame(1'b0, lat, nbusy, ndone);
    check("ones_latency", lat === 576);
    check("ones_busy_cycles", nbusy === 576);
    check("ones_done_count", ndone === 1);
    check("ones_map", bus.fmaps_out === '1);
    check("ones_valid_held", bus.fmaps_valid === 1'b1);

    // Checkerboard
    set_checkerboard();
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 24; c++) begin
        cb_map[0][r][c] = ((r + c) % 2 == 0);
        cb_map[1][r][c] = ((r + c) % 2 != 0);
      end
    for (int ch = 2; ch < 20; ch++) cb_map[ch] = '1;
    run_frame(1'b0, lat, nbusy, ndone);
    check("cb_latency", lat === 576);
    check("cb_map", bus.fmaps_out === cb_map);
    check("cb_00", bus.fmaps_out[0][0][0] === 1'b1);
    check("cb_01", bus.fmaps_out[0][0][1] === 1'b0);
    check("cb_2323", bus.fmaps_out[0][23][23] === 1'b1);
    check("cb_inv_00", bus.fmaps_out[1][0][0] === 1'b0);
    snap = bus.fmaps_out;
    repeat (5) @(posedge clk);
    #1;
    check("idle_valid_held", bus.fmaps_valid === 1'b1);
    check("idle_map_stable", bus.fmaps_out === snap);

    // Threshold extremes
    bus.img_in  = '0;
    bus.weights = '1;
    for (int ch = 0; ch < 20; ch++) bus.thresh[ch] = 5'd0;
    run_frame(1'b0, lat, nbusy, ndone);
    check("th0_latency", lat === 576);
    check("th0_map", bus.fmaps_out === '1);

    bus.img_in = '1;
    for (int ch = 0; ch < 20; ch++) bus.thresh[ch] = 5'd26 + 5'(ch % 6);
    run_frame(1'b0, lat, nbusy, ndone);
    check("th26_map", bus.fmaps_out === '0);

    for (int ch = 0; ch < 20; ch++) bus.thresh[ch] = 5'd25;
    run_frame(1'b0, lat, nbusy, ndone);
    check("th25_map", bus.fmaps_out === '1);

    // Start and image toggling during RUN must not disturb the frame
    set_checkerboard();
    run_frame(1'b1, lat, nbusy, ndone);
    check("tog_latency", lat === 576);
    check("tog_done_count", ndone === 1);
    check("tog_map", bus.fmaps_out === cb_map);

    // Reset at position 100 of an all-ones frame
    bus.img_in  = '1;
    bus.weights = '1;
    for (int ch = 0; ch < 20; ch++) bus.thresh[ch] = 5'd25;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid_pre_bit", bus.fmaps_out[5][3][23] === 1'b1);
    check("mid_pre_busy", bus.busy === 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy === 1'b0);
    check("mid_rst_done", bus.done === 1'b0);
    check("mid_rst_valid", bus.fmaps_valid === 1'b0);
    check("mid_rst_map", bus.fmaps_out === '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_map = '1;
    run_frame(1'b0, lat, nbusy, ndone);
    check("post_rst_latency", lat === 576);
    check("post_rst_done_count", ndone === 1);
    check("post_rst_map", bus.fmaps_out === exp_map);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/conv1_engine.md
# conv1_engine

Sequential first convolution stage of the binary CNN. It latches a 28×28 binary input image and computes 20 binary 24×24 feature maps using a 5×5 XNOR-popcount filter with a per-channel threshold. It produces one output pixel position per cycle, all 20 channels in parallel. Its `fmaps_out` array feeds the 20×24×24 `fmaps_in` of the first pooling stage directly.

## Interface
Parameters: none. Dimensions are fixed by the network: 28×28 input, 20 channels, 5×5 kernel, 24×24 output.

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — request a new frame; accepted only in IDLE.
- `img_in`  in  [0:27][0:27] bit  — binary input image; sampled on the start-accept edge only.
- `weights`  in  [0:19][0:24] bit  — per-channel kernel, index i = 5·kr + kc; must be stable while `busy`.
- `thresh`  in  [0:19][4:0]  — per-channel popcount threshold; must be stable while `busy`.
- `busy`  out  1  — high while computing.
- `done`  out  1  — one-cycle pulse when all 576 positions are written.
- `fmaps_valid`  out  1  — `fmaps_out` holds a complete, consistent frame.
- `fmaps_out`  out  [0:19][0:23][0:23] bit  — registered feature maps.

## Operation
- FSM states:
  - IDLE: start-accept edge latches `img_in` into `img_q`, clears row/col counters, goes to RUN.
  - RUN: 576 cycles, then DONE.
  - DONE: 1 cycle, then IDLE.
- Counters: `r`, `c` are 5 bits, range 0..23, raster order with `c` fastest. At (r=23, c=23) both wrap to 0 and the FSM enters DONE.
- Per RUN cycle, for each channel ch:
  - match[i] = ~(img_q[r+kr][c+kc] ^ weights[ch][i]).
  - pc = popcount(match), 5 bits, range 0..25.
  - `fmaps_out[ch][r][c]` <= (pc >= thresh[ch]), unsigned compare.
- Threshold extremes: thresh = 0 always yields 1; thresh of 26..31 always yields 0.
- `start` while in RUN or DONE is ignored; it does not queue.
- Changing `img_in` after the accept edge has no effect on the frame.
- `fmaps_valid`:
  - set on entry to DONE;
  - cleared on a start-accept edge;
  - held through IDLE, so `fmaps_out` stays stable for the pool stage until the next start.
- `fmaps_out` is not bulk-cleared at start. Positions are overwritten progressively, and `fmaps_valid` = 0 marks the array as mixed.
- Reset (any time, including mid-RUN):
  - state forced to IDLE;
  - `busy`, `done`, `fmaps_valid`, counters, `img_q` and all `fmaps_out` bits go to 0.
- After reset is released, the next `start` runs a full frame normally.

## Timing
- Edge k (IDLE, `start` = 1): after edge k, `busy` = 1 and `fmaps_valid` = 0.
- Edges k+1 … k+576: each edge writes one position, (0,0) at k+1 through (23,23) at k+576.
- After edge k+576: `busy` = 0, `done` = 1, `fmaps_valid` = 1.
- After edge k+577: `done` = 0 and the state is IDLE. The earliest next accept is edge k+578, provided `start` is high at that edge.
- Start-to-done latency: 576 cycles. Frame period: 578 cycles with back-to-back starts.
- No combinational path from `start`, `img_in`, `weights` or `thresh` to any output; all outputs are registered.

## Test plan
- Reset: assert `rst_n` = 0 with random inputs → `busy` = `done` = `fmaps_valid` = 0 and every `fmaps_out` bit = 0. Then `start` → `done` rises exactly 576 cycles after the accept edge.
- All-ones: `img_in` all 1, `weights` all 1, `thresh` = 25 for all channels → all 11520 output bits = 1 at `done`; `busy` high for exactly 576 cycles.
- Checkerboard:
  - stimulus: img[r][c] = (r+c)%2; channel-0 weight[i] = (i/5 + i%5)%2; `thresh[0]` = 25;
  - channel 0: `fmaps_out[0][r][c]` = 1 iff (r+c) is even;
  - channel 1 with inverted weights: result is the exact complement;
  - spot-check (0,0) = 1, (0,1) = 0, (23,23) = 1.
- Threshold bounds:
  - all-0 image, all-1 weights (pc = 0), `thresh` = 0 → all outputs 1;
  - all-1 image, all-1 weights (pc = 25), `thresh` = 26 → all outputs 0;
  - same stimulus with `thresh` = 25 → all outputs 1.
- Ignored inputs: pulse `start` and toggle `img_in` every cycle during RUN → exactly one `done` pulse 576 cycles after the first accept; outputs match the image latched at accept.
- Mid-run reset: assert `rst_n` at position 100 → all outputs immediately 0 and state IDLE. A new all-ones frame completes with all outputs 1 and `done` 576 cycles after its accept.
